acc_cpu_gen2: RTL
=================

ACC_CPU_GEN2 -- requirements
Module: acc_cpu_gen2

Interface
REQ-001 Parameter DATA_W, default 16: word width; ADDR_W = DATA_W-4; legal DATA_W >= 16.
REQ-002 Parameter NCH, default 1: number of byte I/O channels; CH_W = max(1,clog2(NCH)); legal 12+CH_W <= ADDR_W when NCH>1.
REQ-003 clkin  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mem_req  output  1  memory request, held until acknowledged.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-007 mem_addr  output  ADDR_W  word address; valid while mem_req.
REQ-008 mem_wdata  output  DATA_W  write data; valid while mem_req & mem_we.
REQ-009 mem_rdata  input  DATA_W  read data; sampled on the mem_ack cycle.
REQ-010 mem_ack  input  1  transfer completes on a clock edge where mem_req & mem_ack.
REQ-011 in_data  input  8*NCH  channel c byte at [8c+7:8c].
REQ-012 in_valid / in_ready  input / output  NCH  per-channel input handshake.
REQ-013 out_data  output  8  registered output byte, shared by all channels.
REQ-014 out_valid / out_ready  output / input  NCH  per-channel output handshake.
REQ-015 halted  output  1  high after HLT executed.

Function
REQ-016 Instruction fields: I = ir[DATA_W-1], op = ir[DATA_W-2:DATA_W-4], address = ir[ADDR_W-1:0], channel ch = ir[12+CH_W-1:12] (0 when NCH=1); ch >= NCH selects nothing (input/skip conditions false, no pulse).
REQ-017 Memory-reference op 0..6: AND, ADD (carry into E), LDA, STA, BUN, BSA (M[ea]<=PC, PC<=ea+1), ISZ (M[ea]<=M[ea]+1, skip when result 0); I=1 adds one indirect read, ea = word[ADDR_W-1:0].
REQ-018 op 7, I=0, register bits [11:0] in priority order as executed: CLA, CLE, CMA, CME, CIR, CIL, INC, SPA, SNA, SZA, SZE, HLT; CIR/CIL rotate {E,AC} fully, E updated in the same cycle.
REQ-019 op 7, I=1, I/O bits: INP(11), OUT(10), SKI(9), SKO(8), ION(7), IOF(6).
REQ-020 INP: if in_valid[ch], AC[7:0] <= in_data byte, AC upper bits unchanged, in_ready[ch] pulses one cycle; else no change.
REQ-021 OUT: if out_ready[ch], out_data <= AC[7:0] and out_valid[ch] pulses one cycle; else byte dropped, out_data unchanged.
REQ-022 SKI skips when in_valid[ch]; SKO skips when out_ready[ch]; skip = PC+1.
REQ-023 States: FETCH, INDIR, EXEC_RD, EXEC_WR, EXECUTE, INTR, HALT; each memory state holds mem_req and all memory outputs stable until mem_ack, then deasserts mem_req the following cycle.
REQ-024 With mem_ack returned one cycle after mem_req: register/I/O instruction 3 cycles, LDA direct 5 cycles, ISZ direct 7 cycles.
REQ-025 PC and address arithmetic wrap modulo 2^ADDR_W; AC, ISZ increment modulo 2^DATA_W.
REQ-026 HALT: no further memory requests; halted=1; leaves only via rst.
REQ-027 mem_ack while mem_req=0 is ignored.

Reset
REQ-028 rst asserted: PC, AC, IR, DR, E, IEN, R = 0; out_data = 0; mem_req, mem_we, in_ready, out_valid, halted = 0; state FETCH; takes effect immediately, including mid-transfer.
REQ-029 First request after rst deassert: read of address 0.

Configuration
REQ-030 Macro ACC_CPU_GEN2_IRQ_EN defined: ION sets IEN, IOF clears it; at end of each instruction, if IEN and any (in_valid & in_ready-eligible channel) or out_ready for channels < NCH, enter INTR: write PC to M[0], PC <= 1, IEN <= 0.
REQ-031 Macro undefined: ION/IOF are no-ops, no INTR state, IEN/R absent.

Verification
REQ-032 Program LDA 010, ADD 011, STA 012, HLT with M[010]=0x7FFF, M[011]=0x0001 -> M[012]=0x8000, E=0, halted=1.
REQ-033 ISZ on M[020]=0xFFFF -> M[020]=0x0000, following instruction skipped.
REQ-034 NCH=2, DATA_W=20: in_valid=2'b10, in_data[15:8]=0xA5, INP ch1 -> AC[7:0]=0xA5, in_ready=2'b10 one cycle; INP ch0 -> AC unchanged.
REQ-035 mem_ack delayed 5 cycles on every request -> identical final state to REQ-032, mem_req and mem_addr stable throughout each wait.
REQ-036 rst pulsed while STA waits for mem_ack -> mem_req low same cycle, PC=0, next request reads address 0.
REQ-037 IRQ_EN defined: ION, then out_ready[0]=1 -> M[0]=return PC, PC=1, IEN=0; undefined -> no write to M[0].

Source files
------------

// File: rtl/acc_cpu_gen2.sv
// Accumulator CPU with a req/ack memory bus and NCH byte-wide I/O channels.
// Define ACC_CPU_GEN2_IRQ_EN to enable the ION/IOF interrupt mechanism.

module acc_cpu_gen2 #(
  parameter  int DATA_W = 16,
  parameter  int NCH    = 1,
  localparam int ADDR_W = DATA_W - 4,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clkin,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [8*NCH-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [7:0]        out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic              halted
);

  typedef enum logic [2:0] {FETCH, INDIR, EXEC_RD, EXEC_WR, EXECUTE, INTR, HALT} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] pc, ar;
  logic [DATA_W-1:0] ac, ir, dr;
  logic              e, run;

  logic              i_bit, xfer, irq, halt_now;
  logic [2:0]        op;
  logic [CH_W-1:0]   ch;
  logic [NCH-1:0]    ch_hot, in_pulse, out_pulse;
  logic              in_sel, out_sel, e_nx, skip;
  logic [7:0]        in_byte;
  logic [DATA_W-1:0] ac_nx, dr_inc;

  assign i_bit    = ir[DATA_W-1];
  assign op       = ir[DATA_W-2:DATA_W-4];
  assign ch       = (NCH > 1) ? ir[12+CH_W-1:12] : '0;
  assign dr_inc   = dr + 1'b1;
  assign xfer     = mem_req & mem_ack;
  assign halt_now = (op == 3'd7) && !i_bit && ir[0];
  assign halted   = (state == HALT);

`ifdef ACC_CPU_GEN2_IRQ_EN
  logic ien, ien_nx;
  assign irq    = ien && ((|in_valid) || (|out_ready));
  assign ien_nx = (op == 3'd7 && i_bit) ? ((ien | ir[7]) & ~ir[6]) : ien;
`else
  assign irq = 1'b0;
`endif

  // Direct memory-reference ops: STA/BSA only write, BUN needs no operand.
  function automatic state_t mref_state(input logic [2:0] o);
    case (o)
      3'd3, 3'd5: return EXEC_WR;
      3'd4:       return EXECUTE;
      default:    return EXEC_RD;
    endcase
  endfunction

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:
        if (xfer) begin
          if (mem_rdata[DATA_W-2:DATA_W-4] == 3'd7) state_nx = EXECUTE;
          else if (mem_rdata[DATA_W-1])              state_nx = INDIR;
          else state_nx = mref_state(mem_rdata[DATA_W-2:DATA_W-4]);
        end
      INDIR:   if (xfer) state_nx = mref_state(op);
      EXEC_RD: if (xfer) state_nx = EXECUTE;
      EXECUTE:
        if (halt_now)        state_nx = HALT;
        else if (op == 3'd6) state_nx = EXEC_WR;
        else                 state_nx = irq ? INTR : FETCH;
      EXEC_WR: if (xfer) state_nx = irq ? INTR : FETCH;
      INTR:    if (xfer) state_nx = FETCH;
      default: state_nx = HALT;
    endcase
  end

  // run stays low during reset so no request is presented until the first clock after it.
  always_comb begin
    mem_req   = run && (state == FETCH || state == INDIR || state == EXEC_RD ||
                        state == EXEC_WR || state == INTR);
    mem_we    = mem_req && (state == EXEC_WR || state == INTR);
    mem_addr  = ar;
    if (state == FETCH)     mem_addr = pc;
    else if (state == INTR) mem_addr = '0;
    mem_wdata = '0;
    if (state == INTR || (state == EXEC_WR && op == 3'd5)) mem_wdata = DATA_W'(pc);
    else if (state == EXEC_WR && op == 3'd3)               mem_wdata = ac;
    else if (state == EXEC_WR)                             mem_wdata = dr;
  end

  always_comb begin
    ch_hot  = '0;
    in_byte = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_hot[c] = (ch == CH_W'(c));
      if (ch_hot[c]) in_byte = in_data[8*c +: 8];
    end
    in_sel  = |(in_valid & ch_hot);
    out_sel = |(out_ready & ch_hot);
  end

  // Register ops apply in bit order, so later ops and skip tests see earlier results.
  always_comb begin
    ac_nx     = ac;
    e_nx      = e;
    skip      = 1'b0;
    in_pulse  = '0;
    out_pulse = '0;
    case (op)
      3'd0: ac_nx = ac & dr;
      3'd1: {e_nx, ac_nx} = {1'b0, ac} + {1'b0, dr};
      3'd2: ac_nx = dr;
      3'd6: skip = (dr_inc == '0);
      3'd7:
        if (!i_bit) begin
          if (ir[11]) ac_nx = '0;
          if (ir[10]) e_nx = 1'b0;
          if (ir[9])  ac_nx = ~ac_nx;
          if (ir[8])  e_nx = ~e_nx;
          if (ir[7])  {ac_nx, e_nx} = {e_nx, ac_nx};
          if (ir[6])  {e_nx, ac_nx} = {ac_nx, e_nx};
          if (ir[5])  ac_nx = ac_nx + 1'b1;
          if ((ir[4] && !ac_nx[DATA_W-1]) || (ir[3] && ac_nx[DATA_W-1]) ||
              (ir[2] && ac_nx == '0) || (ir[1] && !e_nx))
            skip = 1'b1;
        end else begin
          if (ir[11] && in_sel) begin
            ac_nx[7:0] = in_byte;
            in_pulse   = ch_hot;
          end
          if (ir[10] && out_sel) out_pulse = ch_hot;
          if ((ir[9] && in_sel) || (ir[8] && out_sel)) skip = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      ar        <= '0;
      ac        <= '0;
      ir        <= '0;
      dr        <= '0;
      e         <= 1'b0;
      run       <= 1'b0;
      in_ready  <= '0;
      out_valid <= '0;
      out_data  <= '0;
`ifdef ACC_CPU_GEN2_IRQ_EN
      ien       <= 1'b0;
`endif
    end else begin
      run       <= 1'b1;
      in_ready  <= '0;
      out_valid <= '0;
      case (state)
        FETCH:
          if (xfer) begin
            ir <= mem_rdata;
            ar <= mem_rdata[ADDR_W-1:0];
            pc <= pc + 1'b1;
          end
        INDIR:   if (xfer) ar <= mem_rdata[ADDR_W-1:0];
        EXEC_RD: if (xfer) dr <= mem_rdata;
        EXECUTE: begin
          ac        <= ac_nx;
          e         <= e_nx;
          in_ready  <= in_pulse;
          out_valid <= out_pulse;
          if (|out_pulse) out_data <= ac_nx[7:0];
          if (op == 3'd6) dr <= dr_inc;
          if (op == 3'd4) pc <= ar;
          else if (skip)  pc <= pc + 1'b1;
`ifdef ACC_CPU_GEN2_IRQ_EN
          ien <= ien_nx;
`endif
        end
        EXEC_WR: if (xfer && op == 3'd5) pc <= ar + 1'b1;
        INTR:
          if (xfer) begin
            pc  <= ADDR_W'(1);
`ifdef ACC_CPU_GEN2_IRQ_EN
            ien <= 1'b0;
`endif
          end
        default: ;
      endcase
    end
  end

endmodule
